// File: rtl/class_word_enum.sv
// Enumerates, in ascending order, every 4-bit word that the wildcard priority classifier maps
// to a requested class. The optional out_index port/counter is enabled by CLASS_ENUM_CNT_EN.
module class_word_enum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_class,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_word,
  output logic       out_last
`ifdef CLASS_ENUM_CNT_EN
  ,
  output logic [2:0] out_index
`endif
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e     state_q, state_d;
  logic [1:0] cls_q, cls_d;
  logic [3:0] c_q, c_d;
  logic       match;
  logic       is_last;

  // Priority order matters only conceptually: the three wildcard patterns are disjoint.
  function automatic logic [1:0] classify(input logic [3:0] w);
    logic [1:0] r;
    casez (w)
      4'b?00?: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b010?: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] last_word(input logic [1:0] cls);
    logic [3:0] r;
    case (cls)
      2'd0:    r = 4'b1001;
      2'd1:    r = 4'b1110;
      2'd2:    r = 4'b0101;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  assign match   = (state_q == StScan) && (classify(c_q) == cls_q);
  assign is_last = match && (c_q == last_word(cls_q));

  assign req_ready = (state_q == StIdle);
  assign out_valid = match;
  assign out_word  = c_q;
  assign out_last  = is_last;

`ifdef CLASS_ENUM_CNT_EN
  logic [2:0] idx_q, idx_d;

  assign out_index = idx_q;

  // Hold on the final word so the index never exceeds the class size minus one.
  always_comb begin
    idx_d = idx_q;
    if (!flush) begin
      if (state_q == StIdle && req_valid) begin
        idx_d = 3'd0;
      end else if (match && out_ready && !is_last) begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 3'd0;
    end else begin
      idx_q <= idx_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    c_d     = c_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cls_d   = req_class;
            c_d     = 4'd0;
            state_d = StScan;
          end
        end
        StScan: begin
          // 1111 is always class 3's last word, so c never increments past 15.
          if (!match) begin
            c_d = c_q + 4'd1;
          end else if (out_ready) begin
            if (is_last) begin
              state_d = StIdle;
            end else begin
              c_d = c_q + 4'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cls_q   <= 2'd0;
      c_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      c_q     <= c_d;
    end
  end

endmodule
